multi_capture_timer: RTL and testbench
======================================

# multi_capture_timer

Parametrised, multi-channel successor to the single-channel capture timer in the GPIO block. Each of NCH independent channels measures the time from its enable to its capture gate, with a programmable prescaler, sticky overflow and a rearm path for back-to-back measurements. It sits behind the AXI-Lite register bank and shares the bus clock and reset.

## Interface
- WIDTH, 32: counter width per channel (≥ 2).
- NCH, 4: number of channels (≥ 1).
- PRE_W, 8: prescale field width.
- S_AXI_ACLK  in  1  bus clock; all logic on rising edge.
- AXI_RESET  in  1  asynchronous, active-high reset.
- timer_enable  in  NCH  per-channel run enable.
- capture_gate  in  NCH  per-channel stop/capture request.
- rearm  in  NCH  per-channel restart from HOLD.
- overflow_enable  in  NCH  allow overflow flag to set.
- overflow_clear  in  NCH  clear sticky overflow flag.
- prescale  in  PRE_W  shared divider; tick every prescale+1 cycles.
- capture_complete  out  NCH  high while channel in HOLD.
- overflow_flag  out  NCH  sticky overflow per channel.
- cap_timer_out  out  NCH*WIDTH  channel c count at bits [c*WIDTH +: WIDTH].

## Operation
- Per-channel FSM, states IDLE=2'b00, COUNT=2'b01, HOLD=2'b10; 2'b11 illegal -> IDLE next edge.
- IDLE: count=0, pre_cnt=0; timer_enable=1 -> COUNT.
- COUNT: pre_cnt increments each edge; when pre_cnt ≥ prescale: tick, pre_cnt=0, count+1. capture_gate=1 or timer_enable=0 -> HOLD; count not incremented on that edge.
- HOLD: count frozen. timer_enable=0 -> IDLE (count cleared). Else rearm=1 -> COUNT with count=0, pre_cnt=0. Else stay.
- Count wraps all-ones -> 0 on a tick; on that tick, overflow_flag sets if overflow_enable=1.
- overflow_flag clears on overflow_clear=1 or on IDLE->COUNT; set and clear on same edge: set wins. Flag persists through HOLD and rearm.
- prescale changed mid-count: applies at next comparison; pre_cnt ≥ new value ticks immediately.
- Channels fully independent; only prescale is shared.

## Timing
- Reset: all states IDLE, cap_timer_out=0, overflow_flag=0, capture_complete=0, pre_cnt=0.
- All outputs registered or decoded from registered state; no input-to-output combinational path.
- Enable sampled at edge E0 -> COUNT after E0, count=0. With prescale=0, count=n after n further edges in COUNT.
- Gate sampled at edge Eg -> HOLD after Eg; capture_complete high from Eg; cap_timer_out equals count before Eg.
- rearm sampled at edge Er -> count=0 and capture_complete low after Er.
- Reset asserted mid-count: immediate (asynchronous) return to reset values.

## Configuration
- CAPTURE_SYNC_EN defined: capture_gate, timer_enable and rearm pass through a per-channel 2-flop synchroniser (reset to 0) before the FSM; all input-to-state latencies grow by 2 cycles.
- Undefined: inputs used directly; latencies as in Timing.

## Structure
- Package timer_pkg: state typedef (IDLE/COUNT/HOLD encodings), default WIDTH/PRE_W constants.
- Sub-module capture_channel: one FSM, prescale counter, counter, overflow flag and optional synchroniser; top generates NCH instances and packs outputs.

## Test plan
- NCH=4, prescale=0, enable ch0 at E0, gate at E11 -> cap_timer_out[31:0]=10, capture_complete[0]=1, other channels 0.
- prescale=3, enable ch1, gate after 20 COUNT edges -> count=5; prescale=3 mid-count change to 0 -> increments every cycle thereafter.
- WIDTH=4, overflow_enable=1, run 17 ticks -> count=1, overflow_flag=1; overflow_clear with simultaneous wrap -> flag stays 1.
- HOLD, rearm=1 -> count 0, COUNT resumes, flag retained; timer_enable=0 in HOLD -> IDLE, count 0.
- AXI_RESET mid-count on all channels -> all outputs 0 without a clock edge; illegal state forced -> IDLE next edge.
- CAPTURE_SYNC_EN build: repeat first scenario -> capture value 10, capture_complete rises 2 cycles later.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg
// Shared definitions for multi_capture_timer and its capture_channel
// sub-module: the per-channel state encoding and default parameter values.
// Build option: CAPTURE_SYNC_EN (used in capture_channel) adds input
// synchronisers.
package timer_pkg;

  // Per-channel state encoding; 2'b11 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_COUNT = 2'b01,
    ST_HOLD  = 2'b10
  } tstate_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_PRE_W = 8;
  localparam int DEF_NCH   = 4;

endpackage

// File: rtl/capture_channel.sv
// capture_channel
// One capture timer channel: FSM (IDLE/COUNT/HOLD), prescale counter,
// measurement counter and sticky overflow flag.
// Build option: CAPTURE_SYNC_EN routes timer_enable, capture_gate and rearm
// through a 2-flop synchroniser (reset to 0) before the FSM.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   timer_enable      run enable
//   capture_gate      stop/capture request
//   rearm             restart from HOLD
//   overflow_enable   allow overflow flag to set on wrap
//   overflow_clear    clear sticky overflow flag
//   prescale          tick every prescale+1 cycles
//   capture_complete  high while in HOLD
//   overflow_flag     sticky overflow
//   count_out         current/captured count
module capture_channel
  import timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             timer_enable,
  input  logic             capture_gate,
  input  logic             rearm,
  input  logic             overflow_enable,
  input  logic             overflow_clear,
  input  logic [PRE_W-1:0] prescale,
  output logic             capture_complete,
  output logic             overflow_flag,
  output logic [WIDTH-1:0] count_out
);

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

  logic en;
  logic gate;
  logic rearm_in;

`ifdef CAPTURE_SYNC_EN
  logic [1:0] en_sync;
  logic [1:0] gate_sync;
  logic [1:0] rearm_sync;

  // Two-stage synchronisers for the control inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_sync    <= 2'b00;
      gate_sync  <= 2'b00;
      rearm_sync <= 2'b00;
    end else begin
      en_sync    <= {en_sync[0], timer_enable};
      gate_sync  <= {gate_sync[0], capture_gate};
      rearm_sync <= {rearm_sync[0], rearm};
    end
  end

  assign en       = en_sync[1];
  assign gate     = gate_sync[1];
  assign rearm_in = rearm_sync[1];
`else
  assign en       = timer_enable;
  assign gate     = capture_gate;
  assign rearm_in = rearm;
`endif

  tstate_t          state;
  tstate_t          state_nxt;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_nxt;
  logic [PRE_W-1:0] pre_cnt;
  logic [PRE_W-1:0] pre_nxt;
  logic             flag;
  logic             flag_nxt;
  logic             wrap;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE: begin
        if (en) begin
          state_nxt = ST_COUNT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_COUNT: begin
        if (gate || !en) begin
          state_nxt = ST_HOLD;
        end else begin
          state_nxt = ST_COUNT;
        end
      end
      ST_HOLD: begin
        if (!en) begin
          state_nxt = ST_IDLE;
        end else if (rearm_in) begin
          state_nxt = ST_COUNT;
        end else begin
          state_nxt = ST_HOLD;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode and datapath next values.
  always_comb begin
    count_nxt        = count;
    pre_nxt          = pre_cnt;
    wrap             = 1'b0;
    capture_complete = (state == ST_HOLD);
    case (state)
      ST_IDLE: begin
        count_nxt = '0;
        pre_nxt   = '0;
      end
      ST_COUNT: begin
        // The edge that leaves COUNT freezes the count without ticking.
        if (!gate && en) begin
          // >= so a prescale lowered mid-count below pre_cnt ticks at once.
          if (pre_cnt >= prescale) begin
            pre_nxt   = '0;
            count_nxt = count + CNT_ONE;
            wrap      = &count;
          end else begin
            pre_nxt = pre_cnt + PRE_ONE;
          end
        end else begin
          count_nxt = count;
          pre_nxt   = pre_cnt;
        end
      end
      ST_HOLD: begin
        // Both exits (to IDLE or rearm to COUNT) restart from zero.
        if (state_nxt != ST_HOLD) begin
          count_nxt = '0;
          pre_nxt   = '0;
        end else begin
          count_nxt = count;
          pre_nxt   = pre_cnt;
        end
      end
      default: begin
        count_nxt = '0;
        pre_nxt   = '0;
      end
    endcase

    // A set on the same edge as a clear wins.
    if (wrap && overflow_enable) begin
      flag_nxt = 1'b1;
    end else if (overflow_clear || (state == ST_IDLE && state_nxt == ST_COUNT)) begin
      flag_nxt = 1'b0;
    end else begin
      flag_nxt = flag;
    end
  end

  // Counter, prescaler and overflow flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      pre_cnt <= '0;
      flag    <= 1'b0;
    end else begin
      count   <= count_nxt;
      pre_cnt <= pre_nxt;
      flag    <= flag_nxt;
    end
  end

  assign count_out     = count;
  assign overflow_flag = flag;

endmodule

// File: rtl/multi_capture_timer.sv
// multi_capture_timer
// NCH independent capture timer channels sharing one prescale setting.
// Build option: CAPTURE_SYNC_EN adds 2-flop synchronisers on timer_enable,
// capture_gate and rearm inside every channel (+2 cycles input latency).
// Ports:
//   S_AXI_ACLK        bus clock, rising edge
//   AXI_RESET         asynchronous active-high reset
//   timer_enable      [NCH] per-channel run enable
//   capture_gate      [NCH] per-channel capture request
//   rearm             [NCH] per-channel restart from HOLD
//   overflow_enable   [NCH] allow overflow flag to set
//   overflow_clear    [NCH] clear sticky overflow flag
//   prescale          shared divider, tick every prescale+1 cycles
//   capture_complete  [NCH] high while channel in HOLD
//   overflow_flag     [NCH] sticky overflow per channel
//   cap_timer_out     [NCH*WIDTH] channel c at bits [c*WIDTH +: WIDTH]
module multi_capture_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH   = DEF_NCH,
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic                 S_AXI_ACLK,
  input  logic                 AXI_RESET,
  input  logic [NCH-1:0]       timer_enable,
  input  logic [NCH-1:0]       capture_gate,
  input  logic [NCH-1:0]       rearm,
  input  logic [NCH-1:0]       overflow_enable,
  input  logic [NCH-1:0]       overflow_clear,
  input  logic [PRE_W-1:0]     prescale,
  output logic [NCH-1:0]       capture_complete,
  output logic [NCH-1:0]       overflow_flag,
  output logic [NCH*WIDTH-1:0] cap_timer_out
);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    capture_channel #(
      .WIDTH (WIDTH),
      .PRE_W (PRE_W)
    ) u_ch (
      .clk              (S_AXI_ACLK),
      .rst              (AXI_RESET),
      .timer_enable     (timer_enable[c]),
      .capture_gate     (capture_gate[c]),
      .rearm            (rearm[c]),
      .overflow_enable  (overflow_enable[c]),
      .overflow_clear   (overflow_clear[c]),
      .prescale         (prescale),
      .capture_complete (capture_complete[c]),
      .overflow_flag    (overflow_flag[c]),
      .count_out        (cap_timer_out[c*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_multi_capture_timer.sv
module tb_multi_capture_timer;
  localparam int WIDTH = 4;
  localparam int NCH   = 4;
  localparam int PRE_W = 8;
`ifdef CAPTURE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NCH-1:0]       timer_enable, capture_gate, rearm, overflow_enable, overflow_clear;
  logic [PRE_W-1:0]     prescale;
  logic [NCH-1:0]       capture_complete, overflow_flag;
  logic [NCH*WIDTH-1:0] cap_timer_out;

  multi_capture_timer #(.WIDTH(WIDTH), .NCH(NCH), .PRE_W(PRE_W)) dut (
    .S_AXI_ACLK       (clk),
    .AXI_RESET        (rst),
    .timer_enable     (timer_enable),
    .capture_gate     (capture_gate),
    .rearm            (rearm),
    .overflow_enable  (overflow_enable),
    .overflow_clear   (overflow_clear),
    .prescale         (prescale),
    .capture_complete (capture_complete),
    .overflow_flag    (overflow_flag),
    .cap_timer_out    (cap_timer_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NCH-1:0]       cc;
    logic [NCH-1:0]       of;
    logic [NCH*WIDTH-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model: 0 = stopped, 1 = measuring, 2 = holding a result.
  int m_mode[NCH];
  int m_cnt[NCH];
  int m_pre[NCH];
  bit m_flag[NCH];
  // Input history so control inputs can be seen LAT edges late.
  logic [NCH-1:0] p_te[3], p_cg[3], p_ra[3];

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_mode[c] = 0; m_cnt[c] = 0; m_pre[c] = 0; m_flag[c] = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      p_te[k] = '0; p_cg[k] = '0; p_ra[k] = '0;
    end
  endtask

  task automatic model_edge(input logic [NCH-1:0] te, cg, ra, oe, oc,
                            input logic [PRE_W-1:0] ps);
    logic [NCH-1:0] ete, ecg, era;
    int maxv;
    bit wrapped, started;
    exp_t e;
    maxv = (1 << WIDTH);
    for (int k = 2; k > 0; k--) begin
      p_te[k] = p_te[k-1]; p_cg[k] = p_cg[k-1]; p_ra[k] = p_ra[k-1];
    end
    p_te[0] = te; p_cg[0] = cg; p_ra[0] = ra;
    ete = p_te[LAT]; ecg = p_cg[LAT]; era = p_ra[LAT];
    for (int c = 0; c < NCH; c++) begin
      wrapped = 1'b0;
      started = 1'b0;
      if (m_mode[c] == 0) begin
        m_cnt[c] = 0; m_pre[c] = 0;
        if (ete[c]) begin m_mode[c] = 1; started = 1'b1; end
      end else if (m_mode[c] == 1) begin
        if (ecg[c] || !ete[c]) m_mode[c] = 2;
        else if (m_pre[c] >= int'(ps)) begin
          m_pre[c] = 0;
          wrapped = (m_cnt[c] == maxv - 1);
          m_cnt[c] = (m_cnt[c] + 1) % maxv;
        end else m_pre[c] = m_pre[c] + 1;
      end else begin
        if (!ete[c]) begin m_mode[c] = 0; m_cnt[c] = 0; m_pre[c] = 0; end
        else if (era[c]) begin m_mode[c] = 1; m_cnt[c] = 0; m_pre[c] = 0; end
      end
      if (wrapped && oe[c]) m_flag[c] = 1'b1;
      else if (oc[c] || started) m_flag[c] = 1'b0;
    end
    for (int c = 0; c < NCH; c++) begin
      e.cc[c] = (m_mode[c] == 2);
      e.of[c] = m_flag[c];
      e.cnt[c*WIDTH +: WIDTH] = WIDTH'(m_cnt[c]);
    end
    q.push_back(e);
  endtask

  // Called just after a negedge; drives one cycle and returns at the next negedge.
  task automatic step(input logic [NCH-1:0] te, cg, ra, oe, oc,
                      input logic [PRE_W-1:0] ps);
    timer_enable = te; capture_gate = cg; rearm = ra;
    overflow_enable = oe; overflow_clear = oc; prescale = ps;
    model_edge(te, cg, ra, oe, oc, ps);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string name);
    vectors++;
    if (capture_complete !== '0 || overflow_flag !== '0 || cap_timer_out !== '0) begin
      miscompares++;
      $display("FAIL %s: got cc=%b of=%b cnt=%h, want all zero", name,
               capture_complete, overflow_flag, cap_timer_out);
    end
  endtask

  task automatic do_reset();
    timer_enable = '0; capture_gate = '0; rearm = '0;
    overflow_enable = '0; overflow_clear = '0;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: compares every cycle's outputs against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        if (capture_complete !== e.cc || overflow_flag !== e.of || cap_timer_out !== e.cnt) begin
          miscompares++;
          $display("FAIL outputs @%0t: got cc=%b of=%b cnt=%h, want cc=%b of=%b cnt=%h",
                   $time, capture_complete, overflow_flag, cap_timer_out, e.cc, e.of, e.cnt);
        end
      end
    end
  end

  initial begin
    logic [NCH-1:0] te, cg, ra, oe, oc;
    logic [PRE_W-1:0] ps;
    rst = 1'b1;
    timer_enable = '0; capture_gate = '0; rearm = '0;
    overflow_enable = '0; overflow_clear = '0; prescale = '0;
    model_reset();
    #1;
    check_reset_outputs("reset_state");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Enable ch0 at E0, gate at E11 -> captures 10.
    step(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd0);
    repeat (10) step(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd0);
    step(4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 8'd0);
    repeat (LAT + 3) step(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd0);
    // Disable in HOLD -> IDLE, count cleared.
    repeat (LAT + 2) step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd0);

    // ch1 with prescale=3: 20 COUNT edges then gate -> 5.
    step(4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd3);
    repeat (20) step(4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd3);
    step(4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 8'd3);
    repeat (LAT + 2) step(4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd3);
    // Rearm, run a bit at prescale 3, then drop prescale to 0 mid-count.
    step(4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 8'd3);
    repeat (LAT + 6) step(4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd3);
    repeat (6) step(4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd0);
    repeat (LAT + 2) step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd0);

    // ch2 overflow: 17 ticks -> count 1, flag 1; clear on the next wrap edge.
    step(4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 8'd0);
    repeat (17 + LAT) step(4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 8'd0);
    repeat (14) step(4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 8'd0);
    step(4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 8'd0);
    repeat (3) step(4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 8'd0);
    // Gate then rearm: flag retained; then clear it explicitly.
    step(4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 8'd0);
    repeat (LAT + 1) step(4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 8'd0);
    step(4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 8'd0);
    repeat (LAT + 3) step(4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 8'd0);
    step(4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 8'd0);

    // All channels counting, then asynchronous reset mid-count.
    repeat (LAT + 8) step(4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 8'd0);
    do_reset();

    // Randomised traffic.
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < NCH; c++) begin
        te[c] = ($urandom_range(0, 31) != 0);
        cg[c] = ($urandom_range(0, 39) == 0);
        ra[c] = ($urandom_range(0, 3) == 0);
        oe[c] = ($urandom_range(0, 3) != 0);
        oc[c] = ($urandom_range(0, 15) == 0);
      end
      if ($urandom_range(0, 63) == 0) ps = PRE_W'($urandom_range(0, 3));
      else if (n == 0) ps = 8'd0;
      else ps = prescale;
      step(te, cg, ra, oe, oc, ps);
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
